// File: rtl/mem_pkg.sv
// Shared types and default parameters for the handshaked data-memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DEPTH       = 8192;
  localparam int DEF_WAIT_STATES = 1;
  localparam int CNT_W           = 4;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int DEF_LANES = byte_lanes(DEF_DATA_W);

endpackage

// File: rtl/mem_array.sv
// Storage-only word array: one byte-wide RAM per lane, synchronous write with
// lane enables and a registered read that only updates when rd_en is high.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AW-1:0]                 addr,
  input  logic [byte_lanes(DATA_W)-1:0] wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int LANES = byte_lanes(DATA_W);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane
      logic [7:0] ram [DEPTH];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          ram[addr] <= wr_data[8*gi +: 8];
        end
      end

      // The read register doubles as the "last completed read" holding register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_lane_reg <= '0;
        end else if (rd_en) begin
          rd_lane_reg <= ram[addr];
        end
      end

      assign rd_data[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_ctrl.sv
// Handshaked memory controller: captures one request in IDLE, waits a fixed
// number of cycles, then commits/reads and pulses memReady (with memErr).
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          memR,
  input  logic                          memW,
  input  logic [ADDR_W-1:0]             addr_in,
  input  logic [DATA_W-1:0]             dataW_in,
  input  logic [byte_lanes(DATA_W)-1:0] byteEn,
  output logic [DATA_W-1:0]             mem_out,
  output logic                          memReady,
  output logic                          memErr
);

  localparam int LANES = byte_lanes(DATA_W);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]    DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              is_wr_reg;
  logic              err_reg;
  logic [AW-1:0]     addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [LANES-1:0]  be_reg;
  logic              ready_reg, ready_next;
  logic              merr_reg, merr_next;
  logic              accept;
  logic              commit;
  logic              req_err;
  logic [LANES-1:0]  arr_wr_en;
  logic              arr_rd_en;

  // Range check is done on the full input address so high addresses never alias.
  assign req_err = (memR & memW) | ({1'b0, addr_in} >= DEPTH_LIM);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memR | memW) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    ready_next = commit;
    merr_next  = commit & err_reg;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      merr_reg  <= 1'b0;
      is_wr_reg <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      be_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
      merr_reg  <= merr_next;
      if (accept) begin
        is_wr_reg <= memW;
        err_reg   <= req_err;
        addr_reg  <= addr_in[AW-1:0];
        data_reg  <= dataW_in;
        be_reg    <= byteEn;
      end
    end
  end

  // The array acts on the edge leaving RESP, the same edge memReady rises.
  assign arr_wr_en = (commit && is_wr_reg && !err_reg) ? be_reg : '0;
  assign arr_rd_en = commit && !is_wr_reg && !err_reg;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (CLK),
    .rst_n   (RST_N),
    .addr    (addr_reg),
    .wr_en   (arr_wr_en),
    .wr_data (data_reg),
    .rd_en   (arr_rd_en),
    .rd_data (mem_out)
  );

  assign memReady = ready_reg;
  assign memErr   = merr_reg;

endmodule
